// File: rtl/rt_block_read_seq_pkg.sv
// Shared constants and types for the real-time block read sequencer.
package rt_block_read_seq_pkg;

    // Quadlet index width; a block can never exceed 2**RT_IDX_WIDTH quadlets.
    localparam int RT_IDX_WIDTH = 6;
    localparam int RT_MAX_QUADS = 1 << RT_IDX_WIDTH;

    // Sequencer states.
    typedef enum logic [1:0] {
        RT_IDLE  = 2'd0,
        RT_ARB   = 2'd1,
        RT_ISSUE = 2'd2,
        RT_DRAIN = 2'd3
    } rt_state_e;

    // Quadlets in one RT block: 4 header quadlets, 2 per motor, 5 per encoder.
    function automatic int rt_num_quads(input int num_motors, input int num_encoders);
        return 4 + 2 * num_motors + 5 * num_encoders;
    endfunction

endpackage

// File: rtl/rt_block_read_seq_rd_fifo.sv
// Synchronous show-ahead FIFO holding read data plus its quadlet index tag.
module rt_rd_fifo
    import rt_block_read_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = RT_IDX_WIDTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W+TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge sysclk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= {push_tag, push_data};
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign {head_tag, head_data} = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

    // The issuer's credit check must make overflow and underflow impossible.
    assert property (@(posedge sysclk) disable iff (!reset)
        !(push && !pop && !flush && count_reg == CNT_W'(DEPTH)));
    assert property (@(posedge sysclk) disable iff (!reset)
        !(pop && !flush && count_reg == '0));

endmodule

// File: rtl/rt_block_read_seq.sv
// Sequences one RT block read over the shared register bus and streams the
// returned quadlets (timestamp first) to the packet builder.
module rt_block_read_seq
    import rt_block_read_seq_pkg::*;
#(
    parameter int NUM_MOTORS   = 4,
    parameter int NUM_ENCODERS = 4,
    parameter int RD_LATENCY   = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] timestamp,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] reg_raddr,
    output logic        blk_rt_rd,
    input  logic [31:0] reg_rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int NUM_QUADS = rt_num_quads(NUM_MOTORS, NUM_ENCODERS);
    localparam logic [RT_IDX_WIDTH-1:0] LAST_IDX = RT_IDX_WIDTH'(NUM_QUADS - 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Reject configurations the 6-bit index or the credit scheme cannot handle.
    generate
        if (NUM_QUADS > RT_MAX_QUADS) begin : g_bad_quads
            $error("rt_block_read_seq: block larger than the index range");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
            $error("rt_block_read_seq: RD_LATENCY must be 1..3");
        end
        if (FIFO_DEPTH < RD_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rt_block_read_seq: FIFO_DEPTH must be a power of 2 >= RD_LATENCY+1");
        end
    endgenerate

    rt_state_e               state_reg, state_next;
    logic [RT_IDX_WIDTH-1:0] idx_reg;
    logic [31:0]             ts_reg;
    logic [INF_W-1:0]        in_flight_reg;
    logic                    pipe_valid_reg [RD_LATENCY];
    logic [RT_IDX_WIDTH-1:0] pipe_idx_reg   [RD_LATENCY];

    logic                    issue;
    logic                    start_accept;
    logic                    flush;
    logic                    credit_ok;
    logic                    capture;
    logic [RT_IDX_WIDTH-1:0] capture_idx;
    logic [31:0]             capture_data;
    logic                    pop;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [31:0]             head_data;
    logic [RT_IDX_WIDTH-1:0] head_tag;

    // A new read is allowed only if every outstanding quadlet still has a FIFO slot.
    assign credit_ok = (8'(in_flight_reg) + 8'(fifo_count)) < 8'(FIFO_DEPTH);

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state_reg <= RT_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and bus-side outputs; abort overrides everything outside IDLE.
    always_comb begin
        state_next   = state_reg;
        bus_req      = 1'b0;
        issue        = 1'b0;
        done         = 1'b0;
        start_accept = 1'b0;
        flush        = 1'b0;
        case (state_reg)
            RT_IDLE: begin
                if (start && !abort) begin
                    start_accept = 1'b1;
                    state_next   = RT_ARB;
                end
            end
            RT_ARB: begin
                bus_req = 1'b1;
                if (bus_gnt) state_next = RT_ISSUE;
            end
            RT_ISSUE: begin
                bus_req = 1'b1;
                issue   = bus_gnt && credit_ok;
                if (issue && idx_reg == LAST_IDX) state_next = RT_DRAIN;
            end
            RT_DRAIN: begin
                if (fifo_empty && in_flight_reg == '0) begin
                    done       = 1'b1;
                    state_next = RT_IDLE;
                end
            end
            default: state_next = RT_IDLE;
        endcase
        if (abort && state_reg != RT_IDLE) begin
            issue      = 1'b0;
            done       = 1'b0;
            flush      = 1'b1;
            state_next = RT_IDLE;
        end
    end

    // Issue index and timestamp latch, both armed by an accepted start.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            idx_reg <= '0;
            ts_reg  <= '0;
        end else if (start_accept) begin
            idx_reg <= '0;
            ts_reg  <= timestamp;
        end else if (issue) begin
            idx_reg <= idx_reg + RT_IDX_WIDTH'(1);
        end
    end

    // Latency pipe: follows each issued index until its read data is valid.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_idx_reg[i]   <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_idx_reg[0]   <= idx_reg;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1] && !flush;
                pipe_idx_reg[i]   <= pipe_idx_reg[i-1];
            end
        end
    end

    assign capture      = pipe_valid_reg[RD_LATENCY-1];
    assign capture_idx  = pipe_idx_reg[RD_LATENCY-1];
    assign capture_data = (capture_idx == '0) ? ts_reg : reg_rdata;

    // Reads issued but not yet captured, used for the credit check.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)     in_flight_reg <= '0;
        else if (flush) in_flight_reg <= '0;
        else            in_flight_reg <= in_flight_reg + INF_W'(issue) - INF_W'(capture);
    end

    assign pop = out_valid && out_ready;

    rt_rd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32),
        .TAG_W  (RT_IDX_WIDTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .flush     (flush),
        .push      (capture),
        .push_data (capture_data),
        .push_tag  (capture_idx),
        .pop       (pop),
        .head_data (head_data),
        .head_tag  (head_tag),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign reg_raddr = issue ? {{(16-RT_IDX_WIDTH){1'b0}}, idx_reg} : 16'd0;
    assign blk_rt_rd = issue;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'd0 : head_data;
    assign out_last  = !fifo_empty && (head_tag == LAST_IDX);
    assign busy      = (state_reg != RT_IDLE);

endmodule

// File: tb/tb_rt_block_read_seq.sv
// Randomized bench: a latency-1 and a latency-3 sequencer run side by side
// against a quadlet-level scoreboard.
module tb_rt_block_read_seq;

    localparam int NQ    = 32;
    localparam int DEPTH = 4;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [31:0] timestamp = 32'd0;
    logic        out_ready = 1'b0;
    logic [1:0]  bus_req, bus_gnt, blk_rt_rd, out_valid, out_last, busy, done;
    logic [15:0] reg_raddr [2];
    logic [31:0] reg_rdata [2];
    logic [31:0] out_data  [2];

    rt_block_read_seq dut0 (
        .sysclk(sysclk), .reset(reset), .start(start), .abort(abort), .timestamp(timestamp),
        .bus_req(bus_req[0]), .bus_gnt(bus_gnt[0]), .reg_raddr(reg_raddr[0]), .blk_rt_rd(blk_rt_rd[0]),
        .reg_rdata(reg_rdata[0]), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));

    rt_block_read_seq #(.RD_LATENCY(3), .FIFO_DEPTH(4)) dut1 (
        .sysclk(sysclk), .reset(reset), .start(start), .abort(abort), .timestamp(timestamp),
        .bus_req(bus_req[1]), .bus_gnt(bus_gnt[1]), .reg_raddr(reg_raddr[1]), .blk_rt_rd(blk_rt_rd[1]),
        .reg_rdata(reg_rdata[1]), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int tcyc     = 0;

    // Scoreboard state per instance.
    int beats[2]       = '{0, 0};
    int issued[2]      = '{0, 0};
    int first_issue[2] = '{-1, -1};
    int first_valid[2] = '{-1, -1};
    int first_beat[2]  = '{-1, -1};
    int done_cnt[2]    = '{0, 0};
    bit pend_done[2]   = '{1'b0, 1'b0};

    logic [31:0] ts_exp = 32'd0;
    logic [15:0] salt   = 16'd0;
    int ready_mode    = 0;
    int ready_release = 0;
    int gnt_delay     = 0;
    bit gnt_flaky     = 1'b0;
    int gcnt[2]       = '{0, 0};
    logic [31:0] rpipe [2][3];

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    // Per-cycle scoreboard for one instance, evaluated mid-cycle.
    task automatic mon(input int u);
        logic [31:0] exp_data;
        check_eq($sformatf("u%0d_done", u), 32'(done[u]), 32'(pend_done[u]));
        pend_done[u] = 1'b0;
        if (done[u]) done_cnt[u]++;
        if (blk_rt_rd[u]) begin
            check_eq($sformatf("u%0d_raddr", u), 32'(reg_raddr[u]), 32'(issued[u]));
            check_eq($sformatf("u%0d_issue_gnt", u), 32'(bus_gnt[u]), 32'd1);
            if (issued[u] == 0) first_issue[u] = ncyc;
            issued[u]++;
            check_eq($sformatf("u%0d_outstanding", u), 32'((issued[u] - beats[u]) <= DEPTH), 32'd1);
        end else begin
            check_eq($sformatf("u%0d_raddr_idle", u), 32'(reg_raddr[u]), 32'd0);
        end
        if (out_valid[u] && first_valid[u] < 0 && first_issue[u] >= 0) begin
            first_valid[u] = ncyc;
            check_eq($sformatf("u%0d_first_latency", u), 32'(ncyc - first_issue[u]), 32'(lat_of(u) + 1));
        end
        if (out_valid[u] && out_ready) begin
            exp_data = (beats[u] == 0) ? ts_exp : {salt, 10'd0, 6'(beats[u])};
            check_eq($sformatf("u%0d_data", u), out_data[u], exp_data);
            check_eq($sformatf("u%0d_last", u), 32'(out_last[u]), 32'(beats[u] == NQ - 1));
            if (beats[u] == 0) first_beat[u] = ncyc;
            beats[u]++;
            if (beats[u] == NQ) begin
                pend_done[u] = 1'b1;
                if (u == 0 && ready_mode == 0 && !gnt_flaky)
                    check_eq("u0_throughput", 32'(ncyc - first_beat[0]), 32'(NQ - 1));
            end
        end
    endtask

    always @(negedge sysclk) begin
        ncyc++;
        mon(0);
        mon(1);
    end

    // One clock: echo the addresses issued this cycle into each read pipe,
    // then drive the next cycle's ready, grant and timestamp.
    task automatic tick();
        logic [31:0] w [2];
        @(negedge sysclk);
        for (int u = 0; u < 2; u++) w[u] = blk_rt_rd[u] ? {salt, reg_raddr[u]} : $urandom;
        @(posedge sysclk);
        #1;
        tcyc++;
        for (int u = 0; u < 2; u++) begin
            rpipe[u][2] = rpipe[u][1];
            rpipe[u][1] = rpipe[u][0];
            rpipe[u][0] = w[u];
            reg_rdata[u] = rpipe[u][lat_of(u) - 1];
            if (!bus_req[u]) begin
                bus_gnt[u] = 1'b0;
                gcnt[u]    = 0;
            end else if (gcnt[u] >= gnt_delay) begin
                bus_gnt[u] = gnt_flaky ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                bus_gnt[u] = 1'b0;
                gcnt[u]++;
            end
        end
        timestamp = $urandom;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (tcyc % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (tcyc >= ready_release);
        endcase
    endtask

    task automatic begin_block(input logic [31:0] ts);
        timestamp = ts;
        ts_exp    = ts;
        salt      = 16'($urandom);
        for (int u = 0; u < 2; u++) begin
            beats[u] = 0; issued[u] = 0; done_cnt[u] = 0; pend_done[u] = 1'b0;
            first_issue[u] = -1; first_valid[u] = -1; first_beat[u] = -1;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy != 2'b00 && k < 3000) begin
            tick();
            k++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic end_block(input string tag);
        wait_idle(tag);
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("%s_u%0d_beats", tag, u), 32'(beats[u]), 32'(NQ));
            check_eq($sformatf("%s_u%0d_done_count", tag, u), 32'(done_cnt[u]), 32'd1);
        end
        $display("block %s: ts=0x%08h u0 beats=%0d u1 beats=%0d", tag, ts_exp, beats[0], beats[1]);
    endtask

    task automatic run_block(input string tag, input int mode, input int delay, input bit flaky,
                             input logic [31:0] ts);
        ready_mode = mode;
        gnt_delay  = delay;
        gnt_flaky  = flaky;
        begin_block(ts);
        end_block(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus_gnt = 2'b00;
        for (int u = 0; u < 2; u++) begin
            reg_rdata[u] = 32'd0;
            for (int s = 0; s < 3; s++) rpipe[u][s] = 32'd0;
        end

        // Reset state.
        repeat (3) tick();
        #2;
        check_eq("rst_bus_req",   32'(bus_req),   32'd0);
        check_eq("rst_blk_rt_rd", 32'(blk_rt_rd), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last",  32'(out_last),  32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_done",      32'(done),      32'd0);
        check_eq("rst_out_data0", out_data[0],    32'd0);
        check_eq("rst_raddr1",    32'(reg_raddr[1]), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        run_block("basic",   0, 0,  1'b0, 32'h12345678);
        run_block("ready1of3", 1, 0, 1'b0, $urandom);
        run_block("gnt_delay10", 0, 10, 1'b0, $urandom);

        // Abort after 12 beats, then a clean full block.
        ready_mode = 2; gnt_delay = 0; gnt_flaky = 1'b0;
        begin_block($urandom);
        k = 0;
        while (beats[0] < 12 && k < 2000) begin
            tick();
            k++;
        end
        check_eq("abort_reached_beat12", 32'(beats[0] >= 12), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #2;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_bus_req",   32'(bus_req),   32'd0);
        check_eq("abort_blk_rt_rd", 32'(blk_rt_rd), 32'd0);
        check_eq("abort_busy",      32'(busy),      32'd0);
        repeat (4) tick();
        check_eq("abort_no_done0", 32'(done_cnt[0]), 32'd0);
        check_eq("abort_no_done1", 32'(done_cnt[1]), 32'd0);
        $display("block abort: stopped after u0 beats=%0d u1 beats=%0d", beats[0], beats[1]);
        run_block("after_abort", 0, 0, 1'b0, $urandom);

        // Start pulsed while busy must not restart the block.
        ready_mode = 2; gnt_delay = 2; gnt_flaky = 1'b0;
        begin_block($urandom);
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        end_block("start_busy");

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #2;
        check_eq("start_abort_busy",    32'(busy),    32'd0);
        check_eq("start_abort_bus_req", 32'(bus_req), 32'd0);
        repeat (5) tick();
        check_eq("start_abort_still_idle", 32'(busy), 32'd0);
        check_eq("start_abort_no_issue0", 32'(issued[0]), 32'(NQ));

        // Downstream stalled for a while, flaky grant.
        ready_release = tcyc + 40;
        run_block("stall_then_go", 3, 1, 1'b1, $urandom);

        // Randomized blocks.
        for (int b = 0; b < 4; b++) begin
            run_block($sformatf("rand%0d", b), $urandom_range(0, 2), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
